// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
// Helpers operate on a fixed-width word so they serve any WIDTH below MAX_W;
// callers zero-extend into word_t and slice the low WIDTH bits back out.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_W = 128;

    typedef logic [MAX_W-1:0] word_t;

    // Mask with the low w bits set.
    function automatic word_t width_mask(input int w);
        word_t m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Magnitude of a w-bit operand; two's-complement absolute value when signed.
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    function automatic word_t abs_val(input word_t v, input int w, input logic is_signed);
        if (is_signed && v[w-1]) begin
            return (~v + word_t'(1)) & width_mask(w);
        end
        return v & width_mask(w);
    endfunction

    // Quotient for the short-circuit cases: all ones for divide-by-zero,
    // the most negative value for signed overflow (MIN / -1).
    function automatic word_t special_quot(input int w, input logic div_zero);
        word_t r;
        if (div_zero) begin
            r = width_mask(w);
        end else begin
            r = '0;
            r[w-1] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude, select.
// The dividend register doubles as the quotient register: dividend bits leave
// at the top while quotient bits enter at the bottom.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dvd_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // The remainder is always below the divisor, so WIDTH+1 bits hold the
    // shifted value and the sign of the trial difference is its top bit.
    always_comb begin
        shifted = {rem_in, dvd_in[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        fits    = ~diff[WIDTH];
        rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_out = {dvd_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider for the EX stage.
// Returns quotient and remainder plus a pass-through tag over valid/ready,
// one quotient bit per cycle, with flush cancellation. WIDTH must be 2..127.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r, quot_r, div_mag;
    logic             q_neg, r_neg, special;
    logic [TAG_W-1:0] tag_r;

    logic             accept, calc_last;
    logic             div_zero, overflow, dvd_neg, dvs_neg;
    word_t            dvd_abs_w, dvs_abs_w, spec_q_w;
    logic [WIDTH-1:0] step_rem, step_quot;
    logic             unused_hi;

    assign in_ready  = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign calc_last = special | (cnt == '0);

    // Decode request operands: magnitudes, signs and the short-circuit cases.
    always_comb begin
        dvd_neg   = in_signed & in_dividend[WIDTH-1];
        dvs_neg   = in_signed & in_divisor[WIDTH-1];
        div_zero  = (in_divisor == '0);
        overflow  = in_signed & (in_dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&in_divisor);
        dvd_abs_w = abs_val(word_t'(in_dividend), WIDTH, in_signed);
        dvs_abs_w = abs_val(word_t'(in_divisor), WIDTH, in_signed);
        spec_q_w  = special_quot(WIDTH, div_zero);
    end

    assign unused_hi = ^{dvd_abs_w[MAX_W-1:WIDTH], dvs_abs_w[MAX_W-1:WIDTH], spec_q_w[MAX_W-1:WIDTH]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .dvd_in  (quot_r),
        .dvs     (div_mag),
        .rem_out (step_rem),
        .dvd_out (step_quot)
    );

    // State register.
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides every transition.
    // NOTE: the default assignment first guarantees no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = CALC;
                CALC: if (calc_last) state_nxt = DONE;
                DONE: if (out_ready) state_nxt = accept ? CALC : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: load on accept, iterate in CALC, sign-correct into the outputs.
    // Special cases preload the final result so the CALC pass only registers it.
    // NOTE: datapath and output registers are reset as well so outputs read 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            rem_r    <= '0;
            quot_r   <= '0;
            div_mag  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            special  <= 1'b0;
            tag_r    <= '0;
            out_quot <= '0;
            out_rem  <= '0;
            out_tag  <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt     <= CNT_W'(WIDTH);
            tag_r   <= in_tag;
            special <= div_zero | overflow;
            if (div_zero | overflow) begin
                quot_r  <= spec_q_w[WIDTH-1:0];
                rem_r   <= div_zero ? in_dividend : '0;
                div_mag <= '0;
                q_neg   <= 1'b0;
                r_neg   <= 1'b0;
            end else begin
                quot_r  <= dvd_abs_w[WIDTH-1:0];
                rem_r   <= '0;
                div_mag <= dvs_abs_w[WIDTH-1:0];
                q_neg   <= dvd_neg ^ dvs_neg;
                r_neg   <= dvd_neg;
            end
        end else if (state == CALC) begin
            if (calc_last) begin
                out_quot <= q_neg ? -quot_r : quot_r;
                out_rem  <= r_neg ? -rem_r : rem_r;
                out_tag  <= tag_r;
            end else begin
                rem_r  <= step_rem;
                quot_r <= step_quot;
                cnt    <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
